// File: rtl/tinker_fetch_queue.sv
// Instruction prefetch queue: in-order 32-bit fetches, PC-tagged FIFO, valid/ready to decode.
// Define TINKER_FETCH_PERF_EN to add the perf_fetched/perf_dropped counters.
module tinker_fetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter logic [63:0] RESET_PC        = 64'h2000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [63:0]              mem_req_addr,
    input  logic                     mem_rsp_valid,
    input  logic [31:0]              mem_rsp_data,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [31:0]              dec_inst,
    output logic [63:0]              dec_pc,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   q_count
`ifdef TINKER_FETCH_PERF_EN
    ,
    output logic [31:0]              perf_fetched,
    output logic [31:0]              perf_dropped
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_L = DEPTH[CW:0];
    localparam logic [CW-1:0] MAXO_L  = MAX_OUTSTANDING[CW-1:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e         state_r;
    logic [63:0]    fetch_pc_r;
    logic [63:0]    rsp_pc_r;
    logic [CW-1:0]  out_r;
    logic [CW-1:0]  drop_r;
    logic [CW-1:0]  count_r;
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic           req_valid_r;
    logic           dec_valid_r;
    logic [31:0]    dec_inst_r;
    logic [63:0]    dec_pc_r;
    logic [31:0]    mem_inst_r [DEPTH];
    logic [63:0]    mem_pc_r   [DEPTH];

    state_e         state_next_s;
    logic           req_hs_s;
    logic           rsp_hs_s;
    logic           pop_s;
    logic           push_s;
    logic           drop_rsp_s;
    logic [63:0]    redir_pc_s;
    logic [63:0]    fetch_next_s;
    logic [63:0]    rsp_pc_next_s;
    logic [CW-1:0]  out_next_s;
    logic [CW-1:0]  drop_next_s;
    logic [CW-1:0]  count_next_s;
    logic [AW-1:0]  wr_next_s;
    logic [AW-1:0]  rd_next_s;
    logic           req_valid_next_s;
    logic [31:0]    head_inst_s;
    logic [63:0]    head_pc_s;

    // Next-state computation; outputs are registered from these next values.
    always_comb begin
        req_hs_s      = req_valid_r & mem_req_ready;
        rsp_hs_s      = mem_rsp_valid & (out_r != {CW{1'b0}});
        pop_s         = dec_valid_r & dec_ready;
        drop_rsp_s    = rsp_hs_s & (redirect_valid | (drop_r != {CW{1'b0}}));
        push_s        = rsp_hs_s & ~drop_rsp_s;
        out_next_s    = out_r + CW'(req_hs_s) - CW'(rsp_hs_s);
        redir_pc_s    = redirect_pc & ~64'h3;
        drop_next_s   = drop_r;
        count_next_s  = count_r;
        wr_next_s     = wr_ptr_r;
        rd_next_s     = rd_ptr_r;
        fetch_next_s  = fetch_pc_r;
        rsp_pc_next_s = rsp_pc_r;
        state_next_s  = state_r;

        if (redirect_valid) begin
            // Everything in flight, including this cycle's accepted request, gets dropped.
            drop_next_s   = out_next_s;
            count_next_s  = {CW{1'b0}};
            wr_next_s     = {AW{1'b0}};
            rd_next_s     = {AW{1'b0}};
            fetch_next_s  = redir_pc_s;
            rsp_pc_next_s = redir_pc_s;
            state_next_s  = (out_next_s != {CW{1'b0}}) ? ST_DRAIN : ST_RUN;
        end else begin
            drop_next_s   = drop_r - CW'(drop_rsp_s);
            count_next_s  = count_r + CW'(push_s) - CW'(pop_s);
            wr_next_s     = wr_ptr_r + AW'(push_s);
            rd_next_s     = rd_ptr_r + AW'(pop_s);
            fetch_next_s  = req_hs_s ? (fetch_pc_r + 64'd4) : fetch_pc_r;
            rsp_pc_next_s = push_s ? (rsp_pc_r + 64'd4) : rsp_pc_r;
            case (state_r)
                ST_IDLE:  state_next_s = ST_RUN;
                ST_RUN:   state_next_s = ST_RUN;
                ST_DRAIN: state_next_s = (drop_r == {CW{1'b0}}) ? ST_RUN : ST_DRAIN;
                default:  state_next_s = ST_IDLE;
            endcase
        end

        req_valid_next_s = (state_next_s == ST_RUN) &&
                           (({1'b0, out_next_s} + {1'b0, count_next_s}) < DEPTH_L) &&
                           (out_next_s < MAXO_L);

        head_inst_s = dec_inst_r;
        head_pc_s   = dec_pc_r;
        if (redirect_valid || (count_next_s == {CW{1'b0}})) begin
            head_inst_s = dec_inst_r;
            head_pc_s   = dec_pc_r;
        end else if (count_r == CW'(pop_s)) begin
            // Queue would be empty after the pop, so the new head is the word being pushed.
            head_inst_s = mem_rsp_data;
            head_pc_s   = rsp_pc_r;
        end else begin
            head_inst_s = mem_inst_r[rd_next_s];
            head_pc_s   = mem_pc_r[rd_next_s];
        end
    end

    // Control state, pointers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            fetch_pc_r  <= RESET_PC;
            rsp_pc_r    <= RESET_PC;
            out_r       <= {CW{1'b0}};
            drop_r      <= {CW{1'b0}};
            count_r     <= {CW{1'b0}};
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            req_valid_r <= 1'b0;
            dec_valid_r <= 1'b0;
            dec_inst_r  <= 32'h0;
            dec_pc_r    <= 64'h0;
        end else begin
            state_r     <= state_next_s;
            fetch_pc_r  <= fetch_next_s;
            rsp_pc_r    <= rsp_pc_next_s;
            out_r       <= out_next_s;
            drop_r      <= drop_next_s;
            count_r     <= count_next_s;
            wr_ptr_r    <= wr_next_s;
            rd_ptr_r    <= rd_next_s;
            req_valid_r <= req_valid_next_s;
            dec_valid_r <= (count_next_s != {CW{1'b0}});
            dec_inst_r  <= head_inst_s;
            dec_pc_r    <= head_pc_s;
        end
    end

    // FIFO storage of instruction words and their PC tags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst_r[i] <= 32'h0;
                mem_pc_r[i]   <= 64'h0;
            end
        end else if (push_s) begin
            mem_inst_r[wr_ptr_r] <= mem_rsp_data;
            mem_pc_r[wr_ptr_r]   <= rsp_pc_r;
        end else begin
            mem_inst_r[wr_ptr_r] <= mem_inst_r[wr_ptr_r];
            mem_pc_r[wr_ptr_r]   <= mem_pc_r[wr_ptr_r];
        end
    end

    assign mem_req_valid = req_valid_r;
    assign mem_req_addr  = fetch_pc_r;
    assign dec_valid     = dec_valid_r;
    assign dec_inst      = dec_inst_r;
    assign dec_pc        = dec_pc_r;
    assign q_count       = count_r;

`ifdef TINKER_FETCH_PERF_EN
    logic [31:0]   perf_fetched_r;
    logic [31:0]   perf_dropped_r;
    logic [CW-1:0] flush_cnt_s;
    logic [32:0]   fetched_sum_s;
    logic [32:0]   dropped_sum_s;

    // Flushed entries exclude a same-cycle pop, which decode has consumed.
    always_comb begin
        if (redirect_valid) begin
            flush_cnt_s = count_r - CW'(pop_s);
        end else begin
            flush_cnt_s = {CW{1'b0}};
        end
        fetched_sum_s = {1'b0, perf_fetched_r} + 33'(push_s);
        dropped_sum_s = {1'b0, perf_dropped_r} + 33'(flush_cnt_s) + 33'(drop_rsp_s);
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_r <= 32'h0;
            perf_dropped_r <= 32'h0;
        end else begin
            perf_fetched_r <= fetched_sum_s[32] ? 32'hFFFF_FFFF : fetched_sum_s[31:0];
            perf_dropped_r <= dropped_sum_s[32] ? 32'hFFFF_FFFF : dropped_sum_s[31:0];
        end
    end

    assign perf_fetched = perf_fetched_r;
    assign perf_dropped = perf_dropped_r;
`endif

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Directed bench for tinker_fetch_queue with an in-order, latency-1 memory model.
module tb_tinker_fetch_queue;

    logic        clk            = 1'b0;
    logic        reset          = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready  = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid  = 1'b0;
    logic [31:0] mem_rsp_data   = 32'h0;
    logic        dec_valid;
    logic        dec_ready      = 1'b0;
    logic [31:0] dec_inst;
    logic [63:0] dec_pc;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc    = 64'h0;
    logic [2:0]  q_count;
`ifdef TINKER_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    int          n_vec    = 0;
    int          n_err    = 0;
    int          hs_total = 0;
    int          hs_mark  = 0;
    int          pend_at_req = 0;
    logic        rsp_en   = 1'b1;
    logic        got_req  = 1'b0;
    logic [63:0] first_req_addr = 64'h0;
    logic [63:0] pend_q [$];

    tinker_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .q_count        (q_count)
`ifdef TINKER_FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Memory: responds in request order one cycle after acceptance while rsp_en is high.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q.delete();
            mem_rsp_valid <= 1'b0;
            mem_rsp_data  <= 32'h0;
        end else begin
            if (mem_rsp_valid && pend_q.size() != 0) void'(pend_q.pop_front());
            if (mem_req_valid && mem_req_ready) begin
                pend_q.push_back(mem_req_addr);
                hs_total <= hs_total + 1;
            end
            if (rsp_en && pend_q.size() != 0) begin
                mem_rsp_valid <= 1'b1;
                mem_rsp_data  <= inst_of(pend_q[0]);
            end else begin
                mem_rsp_valid <= 1'b0;
            end
        end
    end

    initial begin
        tick(2);
        check_val("rst_req_valid", {63'h0, mem_req_valid}, 64'h0);
        check_val("rst_addr",      mem_req_addr,           64'h2000);
        check_val("rst_dec_valid", {63'h0, dec_valid},     64'h0);
        check_val("rst_dec_inst",  {32'h0, dec_inst},      64'h0);
        check_val("rst_dec_pc",    dec_pc,                 64'h0);
        check_val("rst_q_count",   {61'h0, q_count},       64'h0);

        // Memory not ready: address parked at the reset PC, nothing outstanding.
        dec_ready = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_val("stall_req_valid", {63'h0, mem_req_valid}, 64'h1);
            check_val("stall_addr",      mem_req_addr,           64'h2000);
        end
        check_val("stall_q_count", {61'h0, q_count}, 64'h0);
        check_val("stall_hs",      64'(hs_total),    64'h0);

        reset = 1'b0;
        tick(2);
        mem_req_ready = 1'b1;
        reset = 1'b1;
        tick(1);
        check_val("str_req_valid", {63'h0, mem_req_valid}, 64'h1);
        check_val("str_addr0",     mem_req_addr,           64'h2000);
        check_val("str_dec_idle0", {63'h0, dec_valid},     64'h0);
        tick(1);
        check_val("str_addr1",     mem_req_addr,           64'h2004);
        check_val("str_dec_idle1", {63'h0, dec_valid},     64'h0);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check_val("str_dec_valid", {63'h0, dec_valid}, 64'h1);
            check_val("str_dec_pc",    dec_pc,             64'h2000 + 64'(4 * i));
            check_val("str_dec_inst",  {32'h0, dec_inst},  {32'h0, inst_of(64'h2000 + 64'(4 * i))});
            check_val("str_addr",      mem_req_addr,       64'h2008 + 64'(4 * i));
        end

        // Decoder stalled: queue fills to DEPTH and requests stop.
        dec_ready = 1'b0;
        tick(6);
        check_val("full_q_count",   {61'h0, q_count},       64'h4);
        check_val("full_req_valid", {63'h0, mem_req_valid}, 64'h0);
        check_val("full_dec_pc",    dec_pc,                 64'h2014);
        check_val("full_addr",      mem_req_addr,           64'h2024);
        hs_mark = hs_total;
        dec_ready = 1'b1;
        tick(1);
        dec_ready = 1'b0;
        check_val("pop1_q_count",   {61'h0, q_count},       64'h3);
        check_val("pop1_dec_pc",    dec_pc,                 64'h2018);
        check_val("pop1_req_valid", {63'h0, mem_req_valid}, 64'h1);
        tick(5);
        check_val("pop1_refill",    {61'h0, q_count},       64'h4);
        check_val("pop1_req_off",   {63'h0, mem_req_valid}, 64'h0);
        check_val("pop1_addr",      mem_req_addr,           64'h2028);
        check_val("pop1_one_req",   64'(hs_total - hs_mark), 64'h1);

        // Responses withheld while the queue drains: two requests end up outstanding.
        rsp_en = 1'b0;
        dec_ready = 1'b1;
        hs_mark = hs_total;
        tick(8);
        check_val("out2_q_count",   {61'h0, q_count},        64'h0);
        check_val("out2_dec_valid", {63'h0, dec_valid},      64'h0);
        check_val("out2_req_valid", {63'h0, mem_req_valid},  64'h0);
        check_val("out2_addr",      mem_req_addr,            64'h2030);
        check_val("out2_hs",        64'(hs_total - hs_mark), 64'h2);

        redirect_valid = 1'b1;
        redirect_pc = 64'h3003;
        tick(1);
        redirect_valid = 1'b0;
        check_val("rd1_req_valid", {63'h0, mem_req_valid}, 64'h0);
        check_val("rd1_addr",      mem_req_addr,           64'h3000);
        check_val("rd1_q_count",   {61'h0, q_count},       64'h0);
        rsp_en = 1'b1;
        got_req = 1'b0;
        for (int k = 0; k < 30 && dec_valid !== 1'b1; k++) begin
            tick(1);
            if (mem_req_valid && !got_req) begin
                got_req = 1'b1;
                first_req_addr = mem_req_addr;
                pend_at_req = pend_q.size();
            end
        end
        check_val("rd1_first_req", first_req_addr,      64'h3000);
        check_val("rd1_drained",   64'(pend_at_req),    64'h0);
        check_val("rd1_dec_seen",  {63'h0, dec_valid},  64'h1);
        check_val("rd1_dec_pc",    dec_pc,              64'h3000);
        check_val("rd1_dec_inst",  {32'h0, dec_inst},   {32'h0, inst_of(64'h3000)});

        // Redirect coinciding with a request handshake, a response and a decode pop.
        tick(3);
        check_val("rd2_pre_pc",        dec_pc,                 64'h300C);
        check_val("rd2_pre_dec_valid", {63'h0, dec_valid},     64'h1);
        check_val("rd2_pre_req_valid", {63'h0, mem_req_valid}, 64'h1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h4000;
        tick(1);
        redirect_valid = 1'b0;
        check_val("rd2_dec_valid", {63'h0, dec_valid},     64'h0);
        check_val("rd2_q_count",   {61'h0, q_count},       64'h0);
        check_val("rd2_req_valid", {63'h0, mem_req_valid}, 64'h0);
        check_val("rd2_addr",      mem_req_addr,           64'h4000);
        for (int k = 0; k < 30 && dec_valid !== 1'b1; k++) begin
            tick(1);
        end
        check_val("rd2_dec_seen", {63'h0, dec_valid}, 64'h1);
        check_val("rd2_dec_pc",   dec_pc,             64'h4000);
        check_val("rd2_dec_inst", {32'h0, dec_inst},  {32'h0, inst_of(64'h4000)});
        tick(1);
        check_val("rd2_dec_pc_next", dec_pc, 64'h4004);

        // Reset asserted mid-DRAIN takes effect without waiting for a clock edge.
        rsp_en = 1'b0;
        tick(6);
        redirect_valid = 1'b1;
        redirect_pc = 64'h5000;
        tick(1);
        redirect_valid = 1'b0;
        check_val("dr_req_valid", {63'h0, mem_req_valid}, 64'h0);
        check_val("dr_addr",      mem_req_addr,           64'h5000);
        #2;
        reset = 1'b0;
        #1;
        check_val("mrst_req_valid", {63'h0, mem_req_valid}, 64'h0);
        check_val("mrst_addr",      mem_req_addr,           64'h2000);
        check_val("mrst_dec_valid", {63'h0, dec_valid},     64'h0);
        check_val("mrst_dec_inst",  {32'h0, dec_inst},      64'h0);
        check_val("mrst_dec_pc",    dec_pc,                 64'h0);
        check_val("mrst_q_count",   {61'h0, q_count},       64'h0);
`ifdef TINKER_FETCH_PERF_EN
        check_val("mrst_perf_fetched", {32'h0, perf_fetched}, 64'h0);
        check_val("mrst_perf_dropped", {32'h0, perf_dropped}, 64'h0);
`endif
        @(negedge clk);
        rsp_en = 1'b1;
        reset = 1'b1;
        tick(2);
        check_val("rel_addr",      mem_req_addr,           64'h2004);
        check_val("rel_req_valid", {63'h0, mem_req_valid}, 64'h1);
        check_val("rel_dec_valid", {63'h0, dec_valid},     64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
